// File: rtl/mem_stage_sram.sv
// MEM-stage bridge from the 32-bit pipeline load/store path to a 16-bit
// asynchronous SRAM: each access runs as a LOW then HIGH halfword phase.
module mem_stage_sram #(
  parameter int          ACCESS_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR     = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_en,
  input  logic        MEM_W_en,
  input  logic [31:0] ALU_result,
  input  logic [31:0] ST_value,
  output logic [31:0] MEM_R_value,
  output logic        freeze,
  output logic [17:0] SRAM_ADDR,
  input  logic [15:0] SRAM_DQ_in,
  output logic [15:0] SRAM_DQ_out,
  output logic        SRAM_DQ_oe,
  output logic        SRAM_WE_N,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2, DONE = 2'd3} state_t;

  localparam logic [3:0] LAST_CYCLE = 4'(ACCESS_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        op_wr;
  logic [16:0] word_idx;
  logic [31:0] st_lat;
  logic [15:0] rd_lo;
  logic        req;
  logic        phase_end;
  logic [31:0] offset;

  assign req       = MEM_R_en | MEM_W_en;
  assign phase_end = (cnt == LAST_CYCLE);
  assign offset    = ALU_result - BASE_ADDR;
  assign state_dbg = state;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    freeze      = 1'b0;
    SRAM_ADDR   = 18'd0;
    SRAM_DQ_out = 16'd0;
    SRAM_DQ_oe  = 1'b0;
    SRAM_WE_N   = 1'b1;
    case (state)
      IDLE: begin
        freeze = req;
        if (req) begin
          state_nxt = LOW;
          cnt_nxt   = 4'd0;
        end
      end
      LOW: begin
        freeze      = 1'b1;
        SRAM_ADDR   = {word_idx, 1'b0};
        SRAM_WE_N   = ~op_wr;
        SRAM_DQ_oe  = op_wr;
        SRAM_DQ_out = op_wr ? st_lat[15:0] : 16'd0;
        if (phase_end) begin
          state_nxt = HIGH;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      HIGH: begin
        freeze      = 1'b1;
        SRAM_ADDR   = {word_idx, 1'b1};
        SRAM_WE_N   = ~op_wr;
        SRAM_DQ_oe  = op_wr;
        SRAM_DQ_out = op_wr ? st_lat[31:16] : 16'd0;
        if (phase_end) begin
          state_nxt = DONE;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Request is captured once in IDLE; inputs are ignored for the rest of the access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_wr       <= 1'b0;
      word_idx    <= 17'd0;
      st_lat      <= 32'd0;
      rd_lo       <= 16'd0;
      MEM_R_value <= 32'd0;
    end else begin
      if (state == IDLE && req) begin
        op_wr    <= MEM_W_en;
        word_idx <= offset[18:2];
        st_lat   <= ST_value;
      end
      if (state == LOW && phase_end && !op_wr)
        rd_lo <= SRAM_DQ_in;
      if (state == HIGH && phase_end && !op_wr)
        MEM_R_value <= {SRAM_DQ_in, rd_lo};
    end
  end

endmodule

// File: tb/tb_mem_stage_sram.sv
// Directed plus randomized bench for mem_stage_sram against a word-level
// memory model and a behavioural 16-bit SRAM.
module tb_mem_stage_sram;

  localparam int          AC   = 2;
  localparam logic [31:0] BASE = 32'd1024;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        MEM_R_en, MEM_W_en;
  logic [31:0] ALU_result, ST_value, MEM_R_value;
  logic        freeze;
  logic [17:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_in, SRAM_DQ_out;
  logic        SRAM_DQ_oe, SRAM_WE_N;
  logic [1:0]  state_dbg;

  mem_stage_sram #(.ACCESS_CYCLES(AC), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .MEM_R_en(MEM_R_en), .MEM_W_en(MEM_W_en),
    .ALU_result(ALU_result), .ST_value(ST_value),
    .MEM_R_value(MEM_R_value), .freeze(freeze),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_in(SRAM_DQ_in),
    .SRAM_DQ_out(SRAM_DQ_out), .SRAM_DQ_oe(SRAM_DQ_oe),
    .SRAM_WE_N(SRAM_WE_N), .state_dbg(state_dbg)
  );

  // behavioural SRAM (halfword array, write on clock edge while strobe low)
  logic [15:0] sram [0:1023];
  assign SRAM_DQ_in = sram[SRAM_ADDR[9:0]];
  always @(posedge clk) if (!SRAM_WE_N) sram[SRAM_ADDR[9:0]] <= SRAM_DQ_out;

  // reference model: 32-bit words keyed by word index
  logic [31:0] ref_mem [int];
  logic [31:0] exp_r;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] widx(input logic [31:0] a);
    logic [31:0] d;
    d = (a - BASE) >> 2;
    return d[16:0];
  endfunction

  function automatic logic [31:0] ref_read(input logic [16:0] w);
    if (ref_mem.exists(int'(w))) return ref_mem[int'(w)];
    return 32'd0;
  endfunction

  // One complete access, starting in IDLE just after a rising edge.
  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    logic [16:0] w;
    logic [31:0] old_r, new_r;
    bit in_lo, in_hi, wr_op;
    w     = widx(a);
    wr_op = wr;
    old_r = exp_r;
    new_r = (rd && !wr) ? ref_read(w) : exp_r;
    MEM_R_en = rd; MEM_W_en = wr; ALU_result = a; ST_value = d;
    for (int k = 0; k <= 2*AC+1; k++) begin
      @(negedge clk);
      in_lo = (k >= 1 && k <= AC);
      in_hi = (k >= AC+1 && k <= 2*AC);
      chk($sformatf("freeze k=%0d", k), 32'(freeze), 32'(k <= 2*AC));
      chk($sformatf("addr k=%0d", k), 32'(SRAM_ADDR),
          in_lo ? 32'({w, 1'b0}) : in_hi ? 32'({w, 1'b1}) : 32'd0);
      chk($sformatf("we_n k=%0d", k), 32'(SRAM_WE_N), 32'(!(wr_op && (in_lo || in_hi))));
      chk($sformatf("oe k=%0d", k), 32'(SRAM_DQ_oe), 32'(wr_op && (in_lo || in_hi)));
      if (wr_op || !(in_lo || in_hi))
        chk($sformatf("dq_out k=%0d", k), 32'(SRAM_DQ_out),
            (wr_op && in_lo) ? 32'(d[15:0]) : (wr_op && in_hi) ? 32'(d[31:16]) : 32'd0);
      chk($sformatf("r_value k=%0d", k), MEM_R_value, (k == 2*AC+1) ? new_r : old_r);
      @(posedge clk); #1;
      if (k == 0) begin
        MEM_R_en = 1'b0; MEM_W_en = 1'b0;
        ALU_result = $urandom; ST_value = $urandom;
      end
    end
    if (wr) ref_mem[int'(w)] = d;
    exp_r = new_r;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) sram[i] = 16'd0;
    rst = 1'b1; MEM_R_en = 1'b0; MEM_W_en = 1'b0; ALU_result = 32'd0; ST_value = 32'd0;
    exp_r = 32'd0;
    #3;
    chk("reset r_value", MEM_R_value, 32'd0);
    chk("reset we_n", 32'(SRAM_WE_N), 32'd1);
    chk("reset oe", 32'(SRAM_DQ_oe), 32'd0);
    chk("reset addr", 32'(SRAM_ADDR), 32'd0);
    chk("reset freeze", 32'(freeze), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'd1028, 32'h0);
    chk("load 1028", MEM_R_value, 32'hDEADBEEF);
    access(1'b1, 1'b1, 32'd1024, 32'h12345678);
    chk("rw keeps value", MEM_R_value, 32'hDEADBEEF);

    // reset during the first HIGH cycle of a store aborts it
    MEM_R_en = 1'b0; MEM_W_en = 1'b1; ALU_result = 32'd1100; ST_value = 32'hCAFEF00D;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      MEM_W_en = 1'b0;
    end
    #1 rst = 1'b1;
    #1;
    chk("abort we_n", 32'(SRAM_WE_N), 32'd1);
    chk("abort oe", 32'(SRAM_DQ_oe), 32'd0);
    chk("abort r_value", MEM_R_value, 32'd0);
    chk("abort addr", 32'(SRAM_ADDR), 32'd0);
    chk("abort freeze", 32'(freeze), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    ref_mem[int'(widx(32'd1100))] = {16'd0, 16'hF00D};
    exp_r = 32'd0;

    access(1'b1, 1'b0, 32'd1024, 32'h0);
    chk("b2b load 1024", MEM_R_value, 32'h12345678);
    access(1'b1, 1'b0, 32'd1028, 32'h0);
    chk("b2b load 1028", MEM_R_value, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'd1100, 32'h0);

    for (int k = 0; k < 10; k++) begin
      ALU_result = $urandom; ST_value = $urandom;
      @(negedge clk);
      chk("idle freeze", 32'(freeze), 32'd0);
      chk("idle we_n", 32'(SRAM_WE_N), 32'd1);
      chk("idle oe", 32'(SRAM_DQ_oe), 32'd0);
      chk("idle addr", 32'(SRAM_ADDR), 32'd0);
      chk("idle r_value", MEM_R_value, exp_r);
      @(posedge clk); #1;
    end

    // address below BASE wraps to the top of the 17-bit word space
    access(1'b0, 1'b1, BASE - 32'd4, 32'hA5A5_5A5A);

    for (int n = 0; n < 40; n++) begin
      int sel;
      logic [31:0] a;
      sel = $urandom_range(0, 2);
      a   = BASE + ($urandom_range(0, 255) << 2) + $urandom_range(0, 3);
      access(sel != 1, sel != 0, a, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
